// File: rtl/host_ahb_sram_slave_pkg.sv
// -----------------------------------------------------------------------------
// host_ahb_sram_slave_pkg
// Shared encodings for the host AHB scratch SRAM responder:
//   - HTRANS / HSIZE / HRESP bus encodings
//   - responder FSM state codes (ADDR, WAIT, ERR1, ERR2)
//   - byte_en(): little-endian byte-lane enables from HSIZE and HADDR[1:0]
// -----------------------------------------------------------------------------
package host_ahb_sram_slave_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    ST_ADDR = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  // Lane n carries bits [8n+7:8n]. Only called for legal accesses, so a
  // halfword never starts on an odd byte.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr;
      HSIZE_HALF: be = 4'b0011 << addr;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/host_ahb_sram_slave_if.sv
// -----------------------------------------------------------------------------
// host_ahb_sram_slave_if
// AHB bus bundle between the host AHB master and the scratch SRAM responder.
//   master modport: drives htrans/hwrite/hsize/hburst/haddr/hwdata
//   slave  modport: drives hrdata/hready/hresp
// Handshake: an address phase is accepted on a rising edge where
// s_ahb_htrans[1]==1 and s_ahb_hready==1; its data phase then runs until the
// next edge with s_ahb_hready==1, and hwdata must be held for all of it.
// -----------------------------------------------------------------------------
interface host_ahb_sram_slave_if;
  logic [1:0]  s_ahb_htrans;
  logic        s_ahb_hwrite;
  logic [2:0]  s_ahb_hsize;
  logic [2:0]  s_ahb_hburst;
  logic [31:0] s_ahb_haddr;
  logic [31:0] s_ahb_hwdata;
  logic [31:0] s_ahb_hrdata;
  logic        s_ahb_hready;
  logic [1:0]  s_ahb_hresp;

  modport slave (
    input  s_ahb_htrans, s_ahb_hwrite, s_ahb_hsize, s_ahb_hburst,
    input  s_ahb_haddr, s_ahb_hwdata,
    output s_ahb_hrdata, s_ahb_hready, s_ahb_hresp
  );

  modport master (
    output s_ahb_htrans, s_ahb_hwrite, s_ahb_hsize, s_ahb_hburst,
    output s_ahb_haddr, s_ahb_hwdata,
    input  s_ahb_hrdata, s_ahb_hready, s_ahb_hresp
  );
endinterface

// File: rtl/host_sram_mem.sv
// -----------------------------------------------------------------------------
// host_sram_mem
// 2^AW x 32 scratch array, shaped like a vendor single-clock RAM macro.
//   clk              : clock
//   i_we/i_widx      : write enable / word index
//   i_wbe/i_wdata    : per-byte write enables / write data
//   i_re/i_ridx      : read enable / word index
//   o_rdata          : registered read data (held while i_re is low)
// Contents are not reset. A same-cycle read of a word being written returns
// the old contents; the caller forwards around that.
// -----------------------------------------------------------------------------
module host_sram_mem #(
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_widx,
  input  logic [3:0]    i_wbe,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_ridx,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [0:(1<<AW)-1];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_wbe[i]) r_mem[i_widx][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_ridx];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/host_ahb_sram_slave.sv
// -----------------------------------------------------------------------------
// host_ahb_sram_slave
// AHB responder fronting a word-organised scratch SRAM: byte/halfword/word
// writes, zero-wait reads with read-after-write forwarding, and two-cycle
// ERROR responses for illegal accesses.
//   clk, reset_n  : clock, asynchronous active-low reset
//   s_bus         : AHB slave modport (host_ahb_sram_slave_if)
//   o_dbg_state   : current responder FSM state
// Optional feature macro: HOST_SRAM_WAIT_EN -- inserts WAIT_CYCLES wait
// states (hready=0, OKAY) before every legal data phase.
// -----------------------------------------------------------------------------
module host_ahb_sram_slave
  import host_ahb_sram_slave_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  host_ahb_sram_slave_if.slave  s_bus,
  output state_t                o_dbg_state
);
  localparam int unsigned AW   = DEPTH_LOG2;
  localparam logic [31:0] BASE = BASE_ADDR;

  state_t        r_state, w_state_nxt;
  logic          w_hready;
  logic [1:0]    w_hresp;
  logic          w_illegal, w_accept, w_legal;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;

  // Data-phase bookkeeping for the transfer accepted in the last address phase.
  logic          r_wr_pend;
  logic [AW-1:0] r_wr_idx;
  logic [3:0]    r_wr_be;
  logic          r_rd_dphase;
  logic [3:0]    r_fwd_be;
  logic [31:0]   r_fwd_data;
  logic [31:0]   r_hrdata;

  logic [31:0]   w_mem_rdata, w_rd_word;
  logic          w_mem_we, w_mem_re;
  logic [2:0]    w_unused_burst;

  // Every beat is decoded on its own, so the burst type carries no information.
  assign w_unused_burst = s_bus.s_ahb_hburst;

  // ---------------------------------------------------------------- decode
  assign w_idx = s_bus.s_ahb_haddr[AW+1:2];
  assign w_be  = byte_en(s_bus.s_ahb_hsize, s_bus.s_ahb_haddr[1:0]);

  always_comb begin
    w_illegal = 1'b0;
    if (s_bus.s_ahb_haddr[31:AW+2] != BASE[31:AW+2]) w_illegal = 1'b1;
    if (s_bus.s_ahb_hsize > HSIZE_WORD) w_illegal = 1'b1;
    if (s_bus.s_ahb_hsize == HSIZE_HALF && s_bus.s_ahb_haddr[0]) w_illegal = 1'b1;
    if (s_bus.s_ahb_hsize == HSIZE_WORD && s_bus.s_ahb_haddr[1:0] != 2'b00) w_illegal = 1'b1;
  end

  assign w_accept = s_bus.s_ahb_htrans[1] & w_hready;
  assign w_legal  = w_accept & ~w_illegal;

  // ----------------------------------------------------------- wait states
`ifdef HOST_SRAM_WAIT_EN
  logic [3:0] r_wait_cnt;

  // Loaded with WAIT_CYCLES-1 so WAIT lasts exactly WAIT_CYCLES cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= 4'd0;
    end else if (w_legal) begin
      r_wait_cnt <= 4'(WAIT_CYCLES - 1);
    end else if (r_state == ST_WAIT && r_wait_cnt != 4'd0) begin
      r_wait_cnt <= r_wait_cnt - 4'd1;
    end
  end
`else
  logic [3:0] w_unused_wait;
  assign w_unused_wait = 4'(WAIT_CYCLES);
`endif

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_ADDR;
    else          r_state <= w_state_nxt;
  end

  // ERR2 completes the error data phase with hready=1, so it accepts the
  // next address phase exactly like ADDR does.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ADDR, ST_ERR2: begin
        w_state_nxt = ST_ADDR;
        if (w_accept && w_illegal) w_state_nxt = ST_ERR1;
`ifdef HOST_SRAM_WAIT_EN
        else if (w_legal) w_state_nxt = ST_WAIT;
`endif
      end
      ST_ERR1: w_state_nxt = ST_ERR2;
      ST_WAIT: begin
`ifdef HOST_SRAM_WAIT_EN
        if (r_wait_cnt == 4'd0) w_state_nxt = ST_ADDR;
`else
        w_state_nxt = ST_ADDR;
`endif
      end
      default: w_state_nxt = ST_ADDR;
    endcase
  end

  always_comb begin
    w_hready = 1'b1;
    w_hresp  = HRESP_OKAY;
    case (r_state)
      ST_WAIT: w_hready = 1'b0;
      ST_ERR1: begin
        w_hready = 1'b0;
        w_hresp  = HRESP_ERROR;
      end
      ST_ERR2: w_hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  // ------------------------------------------------------ data-phase state
  // Only advances on hready=1, the last cycle of the current data phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_pend   <= 1'b0;
      r_wr_idx    <= '0;
      r_wr_be     <= 4'd0;
      r_rd_dphase <= 1'b0;
      r_fwd_be    <= 4'd0;
      r_fwd_data  <= 32'd0;
      r_hrdata    <= 32'd0;
    end else if (w_hready) begin
      r_wr_pend   <= w_legal & s_bus.s_ahb_hwrite;
      r_wr_idx    <= w_idx;
      r_wr_be     <= w_be;
      r_rd_dphase <= w_legal & ~s_bus.s_ahb_hwrite;
      if (r_rd_dphase) r_hrdata <= w_rd_word;
      // The RAM read issued this cycle sees the word before the write that
      // commits on this same edge, so remember the lanes being written.
      r_fwd_be    <= (r_wr_pend && r_wr_idx == w_idx) ? r_wr_be : 4'd0;
      r_fwd_data  <= s_bus.s_ahb_hwdata;
    end
  end

  assign w_mem_we = r_wr_pend & w_hready;
  assign w_mem_re = w_legal & ~s_bus.s_ahb_hwrite;

  host_sram_mem #(.AW(AW)) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_widx  (r_wr_idx),
    .i_wbe   (r_wr_be),
    .i_wdata (s_bus.s_ahb_hwdata),
    .i_re    (w_mem_re),
    .i_ridx  (w_idx),
    .o_rdata (w_mem_rdata)
  );

  always_comb begin
    w_rd_word = w_mem_rdata;
    for (int i = 0; i < 4; i++) begin
      if (r_fwd_be[i]) w_rd_word[8*i +: 8] = r_fwd_data[8*i +: 8];
    end
  end

  // ----------------------------------------------------------------- outputs
  assign s_bus.s_ahb_hrdata = r_rd_dphase ? w_rd_word : r_hrdata;
  assign s_bus.s_ahb_hready = w_hready;
  assign s_bus.s_ahb_hresp  = w_hresp;
  assign o_dbg_state        = r_state;

endmodule
